// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates from a VGA-timed h_sync/v_sync/DE stream
// and checks line, frame, sync and active lengths, declaring lock after consecutive good frames.
module vga_timing_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       err_h,
  output logic       err_v,
  output logic       err_de,
  output logic [9:0] h_total_meas
);
  localparam logic [9:0] P_HA = H_ACTIVE[9:0];
  localparam logic [9:0] P_HT = H_TOTAL[9:0];
  localparam logic [9:0] P_HS = H_SYNC[9:0];
  localparam logic [9:0] P_VA = V_ACTIVE[9:0];
  localparam logic [9:0] P_VT = V_TOTAL[9:0];
  localparam logic [9:0] P_VS = V_SYNC[9:0];
  localparam logic [2:0] P_LF = LOCK_FRAMES[2:0];
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t     r_state;
  logic       r_hs_p, r_vs_p, r_de_p, r_line_ok;
  logic [9:0] r_h_cnt, r_hs_w, r_lines, r_vs_w, r_de_run, r_act_lines;
  logic [2:0] r_good;
  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_de_fall, w_chk;
  logic       w_err_h, w_err_v, w_err_de, w_err;
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction
  always_comb begin
    w_hs_fall = r_hs_p & ~h_sync;
    w_hs_rise = ~r_hs_p & h_sync;
    w_vs_fall = r_vs_p & ~v_sync;
    w_de_fall = r_de_p & ~DE;
    w_chk     = r_state != SEARCH;
    // a line with no hsync fall is flagged once, as h_cnt steps onto its saturation value
    w_err_h   = w_chk & ((w_hs_fall & r_line_ok & (sat_inc(r_h_cnt) != P_HT)) |
                         (w_hs_rise & (r_hs_w != P_HS)) |
                         (~w_hs_fall & (r_h_cnt == 10'd1022)));
    w_err_v   = w_chk & w_vs_fall & ((r_lines != P_VT) | (r_vs_w != P_VS));
    w_err_de  = w_chk & ((w_de_fall & (r_de_run != P_HA)) | (w_vs_fall & (r_act_lines != P_VA)));
    w_err     = w_err_h | w_err_v | w_err_de;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_hs_p       <= 1'b1;
      r_vs_p       <= 1'b1;
      r_de_p       <= 1'b0;
      r_line_ok    <= 1'b0;
      r_good       <= '0;
      r_h_cnt      <= '0;
      r_hs_w       <= '0;
      r_lines      <= '0;
      r_vs_w       <= '0;
      r_de_run     <= '0;
      r_act_lines  <= '0;
      x_pixel      <= '0;
      y_pixel      <= '0;
      pix_valid    <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      err_h        <= 1'b0;
      err_v        <= 1'b0;
      err_de       <= 1'b0;
      h_total_meas <= '0;
    end else begin
      pix_valid   <= pclk & DE;
      frame_start <= pclk & w_vs_fall;
      err_h       <= pclk & w_err_h;
      err_v       <= pclk & w_err_v;
      err_de      <= pclk & w_err_de;
      if (pclk) begin
        r_hs_p      <= h_sync;
        r_vs_p      <= v_sync;
        r_de_p      <= DE;
        r_h_cnt     <= w_hs_fall ? '0 : sat_inc(r_h_cnt);
        r_hs_w      <= w_hs_rise ? '0 : h_sync ? r_hs_w : sat_inc(r_hs_w);
        // a coincident hsync/DE fall belongs to the frame that the vsync fall opens
        r_lines     <= w_vs_fall ? {9'd0, w_hs_fall} : w_hs_fall ? sat_inc(r_lines) : r_lines;
        r_vs_w      <= w_vs_fall ? {9'd0, w_hs_fall} : (w_hs_fall & ~v_sync) ? sat_inc(r_vs_w) : r_vs_w;
        r_de_run    <= w_de_fall ? '0 : DE ? sat_inc(r_de_run) : r_de_run;
        r_act_lines <= w_vs_fall ? {9'd0, w_de_fall} : w_de_fall ? sat_inc(r_act_lines) : r_act_lines;
        if (w_hs_fall) h_total_meas <= sat_inc(r_h_cnt);
        if (DE) x_pixel <= r_de_p ? x_pixel + 10'd1 : '0;
        if (w_vs_fall) y_pixel <= '0;
        else if (w_de_fall) y_pixel <= y_pixel + 10'd1;
        if (r_state == SEARCH) begin
          if (w_vs_fall) begin
            r_state   <= VERIFY;
            r_good    <= '0;
            r_line_ok <= 1'b0;
          end
        end else if (w_err) begin
          r_state <= SEARCH;
          locked  <= 1'b0;
        end else begin
          if (w_hs_fall) r_line_ok <= 1'b1;
          if (w_vs_fall && r_state == VERIFY) begin
            r_good <= r_good + 3'd1;
            if (r_good + 3'd1 == P_LF) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: scaled-down VGA stream with random strobe spacing and idle-cycle noise,
// checked strobe by strobe against an index-based timing model.
module tb_vga_timing_monitor;
  localparam int HA = 20, HT = 32, HS = 4, HBP = 4;
  localparam int VA = 10, VT = 16, VS = 2, VBP = 2, LF = 2;
  logic clk = 0, reset = 1, pclk = 0, h_sync = 1, v_sync = 1, DE = 0;
  logic [9:0] x_pixel, y_pixel, h_total_meas;
  logic pix_valid, frame_start, locked, err_h, err_v, err_de;
  vga_timing_monitor #(.H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HS), .V_ACTIVE(VA),
    .V_TOTAL(VT), .V_SYNC(VS), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .pclk(pclk), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .err_h(err_h), .err_v(err_v), .err_de(err_de), .h_total_meas(h_total_meas));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int n, t_hsf, t_der, lines, vs_w, act, y_m, meas, mode, good, line_ok, lk_m;
  bit ph, pv, pd, e_pv, e_fs, e_eh, e_ev, e_ed;
  int e_x;
  int fs_cnt, n_eh, n_ed, fr_pv, fr_corner, pv_cnt, corner_cnt;
  bit armed, prev_lk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int cap(input int v);
    return v > 1023 ? 1023 : v;
  endfunction
  task automatic model_reset();
    ph = 1; pv = 1; pd = 0; t_hsf = n - 1; t_der = n;
    lines = 0; vs_w = 0; act = 0; y_m = 0; meas = 0; mode = 0; good = 0; line_ok = 0; lk_m = 0;
    armed = 1; fs_cnt = 0; prev_lk = 0;
  endtask
  // expectations come from strobe indices of the last hsync fall / DE rise
  task automatic model_step(input bit hs, input bit vs, input bit de);
    bit hf, hr, vf, dr, df;
    hf = ph && !hs; hr = !ph && hs; vf = pv && !vs; dr = !pd && de; df = pd && !de;
    e_eh = mode != 0 && ((hf && line_ok != 0 && cap(n - t_hsf) != HT) ||
                         (hr && cap(n - t_hsf) != HS) || (!hf && n - t_hsf - 1 == 1022));
    e_ev = mode != 0 && vf && (lines != VT || vs_w != VS);
    e_ed = mode != 0 && ((df && cap(n - t_der) != HA) || (vf && act != VA));
    e_fs = vf; e_pv = de;
    if (de) e_x = dr ? 0 : (n - t_der) % 1024;
    if (vf) y_m = 0; else if (df) y_m = (y_m + 1) % 1024;
    if (hf) meas = cap(n - t_hsf);
    lines = vf ? int'(hf) : lines + int'(hf);
    vs_w  = vf ? int'(hf) : vs_w + int'(hf && !vs);
    act   = vf ? int'(df) : act + int'(df);
    if (mode == 0) begin
      if (vf) begin mode = 1; good = 0; line_ok = 0; end
    end else if (e_eh || e_ev || e_ed) begin
      mode = 0; lk_m = 0;
    end else begin
      if (hf) line_ok = 1;
      if (vf && mode == 1) begin
        good++;
        if (good == LF) begin mode = 2; lk_m = 1; end
      end
    end
    if (hf) t_hsf = n;
    if (dr) t_der = n;
    ph = hs; pv = vs; pd = de; n++;
  endtask
  task automatic strobe(input bit hs, input bit vs, input bit de);
    @(negedge clk);
    h_sync = hs; v_sync = vs; DE = de; pclk = 1;
    model_step(hs, vs, de);
    @(posedge clk); #1;
    check("pix_valid", pix_valid, e_pv);
    check("frame_start", frame_start, e_fs);
    check("err_h", err_h, e_eh);
    check("err_v", err_v, e_ev);
    check("err_de", err_de, e_ed);
    check("locked", locked, lk_m);
    check("h_total_meas", h_total_meas, meas);
    if (e_pv) begin
      check("x_pixel", x_pixel, e_x);
      check("y_pixel", y_pixel, y_m);
    end
    if (frame_start) fs_cnt++;
    if (err_h) n_eh++;
    if (err_de) n_ed++;
    if (pix_valid) begin
      fr_pv++;
      if (x_pixel == 10'(HA - 1) && y_pixel == 10'(VA - 1)) fr_corner++;
    end
    if (locked && !prev_lk && armed) begin
      check("lock_after_3rd_vsync_fall", fs_cnt, 3);
      armed = 0;
    end
    prev_lk = locked;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      pclk = 0; h_sync = 1'($urandom); v_sync = 1'($urandom); DE = 1'($urandom);
      @(posedge clk); #1;
      check("pulses_idle", {pix_valid, frame_start, err_h, err_v, err_de}, 0);
    end
  endtask
  task automatic check_all_zero(input string tag);
    check(tag, {x_pixel, y_pixel, pix_valid, frame_start, locked, err_h, err_v, err_de, h_total_meas}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    pclk = 0; #2 reset = 1; #1;
    check_all_zero("async_reset_outputs");
    @(posedge clk); #1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask
  task automatic gen_frame(input int stretch_l, input int drop_l, input int rst_l);
    fr_pv = 0; fr_corner = 0;
    for (int l = 0; l < VT; l++)
      for (int p = 0; p < HT + int'(l == stretch_l); p++) begin
        if (l == rst_l && p == HS + 6) do_reset();
        strobe(p >= HS, l >= VS, l >= VS + VBP && l < VS + VBP + VA && l != drop_l &&
               p >= HS + HBP && p < HS + HBP + HA);
      end
    pv_cnt = fr_pv; corner_cnt = fr_corner;
  endtask
  initial begin
    int eh0, ed0;
    n = 0; n_eh = 0; n_ed = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (4) gen_frame(-1, -1, -1);
    check("locked_initial", locked, 1);
    check("meas_locked", h_total_meas, HT);
    check("pix_per_frame", pv_cnt, HA * VA);
    check("corner_once", corner_cnt, 1);
    check("no_err_initial", n_eh + n_ed, 0);
    eh0 = n_eh;
    gen_frame(5, -1, -1);
    check("stretch_err_h", n_eh - eh0, 1);
    check("stretch_unlocked", locked, 0);
    repeat (3) gen_frame(-1, -1, -1);
    check("relock_after_stretch", locked, 1);
    ed0 = n_ed;
    gen_frame(-1, VS + VBP + 3, -1);
    check("de_drop_no_err_yet", n_ed - ed0, 0);
    gen_frame(-1, -1, -1);
    check("de_drop_err_de", n_ed - ed0, 1);
    repeat (3) gen_frame(-1, -1, -1);
    check("locked_before_reset", locked, 1);
    gen_frame(-1, -1, 8);
    repeat (3) gen_frame(-1, -1, -1);
    check("relock_after_reset", locked, 1);
    check("relock_pix_per_frame", pv_cnt, HA * VA);
    eh0 = n_eh;
    repeat (1100) strobe(1, 1, 0);
    check("stuck_err_h", n_eh - eh0, 1);
    check("stuck_unlocked", locked, 0);
    check("stuck_meas_hold", h_total_meas, HT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
